// File: rtl/decode_stage.sv
// RV32I/RV64I integer decode stage: decodes one instruction into a registered
// ALU-control bundle with valid/ready handshakes, halting after EBREAK/illegal.
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_aluop,
  output logic            out_wen,
  output logic            out_src1_pc,
  output logic            out_src2_imm,
  output logic            out_jump,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t state, state_nxt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_j;
  logic        is_ebreak;
  logic        sll_ok, sr_ok;
  logic        accept;

  logic [3:0]  d_aluop;
  logic        d_wen, d_src1_pc, d_src2_imm, d_jump, d_illegal;
  logic [31:0] d_imm;

  assign opcode    = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign funct7    = in_inst[31:25];
  assign imm_i     = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u     = {in_inst[31:12], 12'b0};
  assign imm_j     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
  assign is_ebreak = (in_inst == 32'h0010_0073);

  // RV64 shifts borrow inst[25] as shamt[5], so only inst[31:26] is checked.
  if (XLEN == 32) begin : g_shift32
    assign sll_ok = (in_inst[31:25] == 7'b0000000);
    assign sr_ok  = (in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000);
  end else begin : g_shift64
    assign sll_ok = (in_inst[31:26] == 6'b000000);
    assign sr_ok  = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
  end

  always_comb begin
    d_aluop    = ALU_ADD;
    d_wen      = 1'b0;
    d_src1_pc  = 1'b0;
    d_src2_imm = 1'b0;
    d_jump     = 1'b0;
    d_imm      = '0;
    d_illegal  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        d_src2_imm = 1'b1;
        d_wen      = 1'b1;
        d_imm      = imm_i;
        case (funct3)
          3'b000: d_aluop = ALU_ADD;
          3'b010: d_aluop = ALU_SLT;
          3'b011: d_aluop = ALU_SLTU;
          3'b100: d_aluop = ALU_XOR;
          3'b110: d_aluop = ALU_OR;
          3'b111: d_aluop = ALU_AND;
          3'b001: begin
            d_aluop   = ALU_SLL;
            d_illegal = !sll_ok;
          end
          default: begin
            d_aluop   = in_inst[30] ? ALU_SRA : ALU_SRL;
            d_illegal = !sr_ok;
          end
        endcase
      end
      OPC_OP: begin
        d_wen = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  d_aluop = ALU_ADD;
            3'b001:  d_aluop = ALU_SLL;
            3'b010:  d_aluop = ALU_SLT;
            3'b011:  d_aluop = ALU_SLTU;
            3'b100:  d_aluop = ALU_XOR;
            3'b101:  d_aluop = ALU_SRL;
            3'b110:  d_aluop = ALU_OR;
            default: d_aluop = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          d_aluop = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          d_aluop = ALU_SRA;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d_aluop    = ALU_PASSB;
        d_src2_imm = 1'b1;
        d_wen      = 1'b1;
        d_imm      = imm_u;
      end
      OPC_AUIPC: begin
        d_src1_pc  = 1'b1;
        d_src2_imm = 1'b1;
        d_wen      = 1'b1;
        d_imm      = imm_u;
      end
      OPC_JAL: begin
        d_jump     = 1'b1;
        d_wen      = 1'b1;
        d_src1_pc  = 1'b1;
        d_src2_imm = 1'b1;
        d_imm      = imm_j;
      end
      OPC_JALR: begin
        d_jump     = 1'b1;
        d_wen      = 1'b1;
        d_src2_imm = 1'b1;
        d_imm      = imm_i;
        d_illegal  = (funct3 != 3'b000);
      end
      OPC_SYSTEM: d_illegal = !is_ebreak;
      default:    d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_aluop    = ALU_ADD;
      d_wen      = 1'b0;
      d_jump     = 1'b0;
      d_src1_pc  = 1'b0;
      d_src2_imm = 1'b0;
      d_imm      = '0;
    end
    if (in_inst[11:7] == 5'd0) d_wen = 1'b0;
  end

  assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt = state;
    if (state == RUN && accept && (d_illegal || is_ebreak)) state_nxt = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_aluop    <= '0;
      out_wen      <= 1'b0;
      out_src1_pc  <= 1'b0;
      out_src2_imm <= 1'b0;
      out_jump     <= 1'b0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_aluop    <= d_aluop;
      out_wen      <= d_wen;
      out_src1_pc  <= d_src1_pc;
      out_src2_imm <= d_src2_imm;
      out_jump     <= d_jump;
      out_imm      <= XLEN'($signed(d_imm));
      out_rs1      <= in_inst[19:15];
      out_rs2      <= in_inst[24:20];
      out_rd       <= in_inst[11:7];
      out_illegal  <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: one XLEN=64 and one XLEN=32 instance, each
// with its own driver, reference model queue and output monitor.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  aluop;
    logic        wen, src1_pc, src2_imm, jump, illegal, halt;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  task automatic chk(input string name, input int xl, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s xlen=%0d got=%h want=%h", name, xl, got, want);
    end
  endtask

  // Reference decode computed from the ISA rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc, input int xl);
    exp_t e;
    logic [3:0]  f3map [8];
    logic [63:0] mask, i_imm, u_imm, j_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    f3map = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = w[14:12];
    f7 = w[31:25];
    mask = (xl == 32) ? 64'hFFFF_FFFF : '1;
    i_imm = 64'(w[31:20]);
    if (w[31]) i_imm = i_imm - 64'd4096;
    u_imm = 64'(w[31:12]) << 12;
    if (w[31]) u_imm = u_imm - (64'd1 << 32);
    j_imm = 64'({w[31], w[19:12], w[20], w[30:21], 1'b0});
    if (w[31]) j_imm = j_imm - (64'd1 << 21);
    e = '{default: '0};
    e.pc = pc & mask;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd = w[11:7];
    case (w[6:0])
      7'h13: begin
        e.src2_imm = 1; e.wen = 1; e.imm = i_imm; e.aluop = f3map[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (xl == 32) legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          else          legal = (w[31:26] == 6'h00) || (f3 == 3'd5 && w[31:26] == 6'h10);
          e.illegal = !legal;
          if (f3 == 3'd5 && w[30]) e.aluop = 4'd7;
        end
      end
      7'h33: begin
        e.wen = 1; e.aluop = f3map[f3];
        if (f7 == 7'h20 && f3 == 3'd0)      e.aluop = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.aluop = 4'd7;
        else if (f7 != 7'h00)               e.illegal = 1;
      end
      7'h37: begin e.aluop = 4'd10; e.src2_imm = 1; e.wen = 1; e.imm = u_imm; end
      7'h17: begin e.src1_pc = 1; e.src2_imm = 1; e.wen = 1; e.imm = u_imm; end
      7'h6f: begin e.jump = 1; e.wen = 1; e.src1_pc = 1; e.src2_imm = 1; e.imm = j_imm; end
      7'h67: begin
        e.jump = 1; e.wen = 1; e.src2_imm = 1; e.imm = i_imm;
        e.illegal = (f3 != 3'd0);
      end
      7'h73: e.illegal = (w != 32'h0010_0073);
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin e.wen = 0; e.jump = 0; e.aluop = 4'd0; end
    if (e.rd == 5'd0) e.wen = 0;
    e.imm = e.imm & mask;
    e.halt = e.illegal || (w == 32'h0010_0073);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic [19:0] imm20;
    int k;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); imm12 = 12'($urandom); imm20 = 20'($urandom);
    k = $urandom_range(0, 19);
    case (k)
      0, 1, 2, 3, 4, 5, 18, 19: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          case ($urandom_range(0, 7))
            0, 1, 2, 3: f7 = 7'h00;
            4, 5:       f7 = 7'h20;
            6:          f7 = 7'h01;
            default:    f7 = 7'($urandom);
          endcase
          return {f7, rs2, rs1, f3, rd, 7'h13};
        end
        return {imm12, rs1, f3, rd, 7'h13};
      end
      6, 7, 8, 9: begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4: f7 = 7'h00;
          5, 6:          f7 = 7'h20;
          default:       f7 = 7'($urandom);
        endcase
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      10: return {imm20, rd, 7'h37};
      11: return {imm20, rd, 7'h17};
      12, 13: return {imm20, rd, 7'h6f};
      14, 15: begin
        if ($urandom_range(0, 7) != 0) f3 = 3'd0;
        return {imm12, rs1, f3, rd, 7'h67};
      end
      16: return 32'h0010_0073;
      default: return $urandom;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int XL = (gi == 0) ? 64 : 32;

    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_inst;
    logic [XL-1:0] in_pc, out_pc, out_imm;
    logic [3:0]    out_aluop;
    logic          out_wen, out_src1_pc, out_src2_imm, out_jump, out_illegal, halted;
    logic [4:0]    out_rs1, out_rs2, out_rd;

    exp_t q[$];
    logic valid_m, halt_m;

    decode_stage #(.XLEN(XL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_aluop(out_aluop),
      .out_wen(out_wen), .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm),
      .out_jump(out_jump), .out_imm(out_imm), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal),
      .halted(halted)
    );

    task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                        input logic fl, input logic ordy, output logic acc);
      exp_t e;
      logic rdy;
      @(negedge clk);
      in_valid = v; in_inst = w; in_pc = pc[XL-1:0]; flush = fl; out_ready = ordy;
      #1;
      rdy = !halt_m && !fl && (!valid_m || ordy);
      chk("in_ready", XL, 64'(in_ready), 64'(rdy));
      chk("out_valid", XL, 64'(out_valid), 64'(valid_m));
      chk("halted", XL, 64'(halted), 64'(halt_m));
      acc = v && rdy;
      if (acc) begin
        e = model(w, pc, XL);
        q.push_back(e);
        if (e.halt) halt_m = 1'b1;
      end
      valid_m = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : valid_m;
    endtask

    task automatic offer(input logic [31:0] w, input logic [63:0] pc, input int rmode);
      logic acc;
      for (int i = 0; i < 30; i++) begin
        step(1'b1, w, pc, 1'b0, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), acc);
        if (acc) return;
      end
      total++; bad++;
      $display("FAIL offer_timeout xlen=%0d inst=%h not accepted in 30 cycles", XL, w);
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      #1;
      q.delete(); valid_m = 1'b0; halt_m = 1'b0;
      chk("rst_valid", XL, 64'(out_valid), 64'd0);
      chk("rst_halted", XL, 64'(halted), 64'd0);
      chk("rst_pc", XL, 64'(out_pc), 64'd0);
      chk("rst_imm", XL, 64'(out_imm), 64'd0);
      chk("rst_ctl", XL, 64'({out_aluop, out_wen, out_src1_pc, out_src2_imm, out_jump,
                              out_illegal, out_rs1, out_rs2, out_rd}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
    endtask

    initial begin
      logic acc;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0; valid_m = 1'b0; halt_m = 1'b0;
      do_reset();
      offer(32'h0050_0093, 64'h1000, 1);
      offer(32'hFFF0_F113, 64'h1004, 1);
      offer(32'h4020_81B3, 64'h1008, 1);
      offer(32'h1234_52B7, 64'h100C, 1);
      offer(32'h0000_0013, 64'h1010, 1);
      offer(32'hFFFF_F097, 64'h1014, 1);
      offer(32'h0080_00EF, 64'h1018, 1);
      offer(32'h8000_80E7, 64'h101C, 1);
      offer(32'h4010_D093, 64'h1020, 1);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);
      // backpressure: A held, B waits, then B drains
      offer(32'h0070_0193, 64'h2000, 0);
      step(1'b1, 32'h0080_0213, 64'h2004, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0080_0213, 64'h2004, 1'b0, 1'b0, acc);
      offer(32'h0080_0213, 64'h2004, 1);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);
      // flush drops the held bundle and rejects the concurrent offer
      offer(32'h0090_0293, 64'h3000, 0);
      step(1'b1, 32'h00A0_0313, 64'h3004, 1'b1, 1'b0, acc);
      offer(32'h00A0_0313, 64'h3004, 1);
      step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);
      // halting instructions
      offer(32'h0010_0073, 64'h4000, 1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0013, 64'h4004, 1'b0, 1'b1, acc);
      do_reset();
      offer(32'hFFFF_FFFF, 64'h5000, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0013, 64'h5004, 1'b0, 1'b1, acc);
      do_reset();
      offer(32'h0200_9093, 64'h6000, 1);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);
      do_reset();
      for (int n = 0; n < 1200; n++) begin
        if (halt_m) do_reset();
        case ($urandom_range(0, 15))
          0: step(1'($urandom_range(0, 1)), rand_inst(), {$urandom, $urandom}, 1'b1,
                  1'($urandom_range(0, 1)), acc);
          1: step(1'b0, 32'h0, 64'h0, 1'b0, 1'($urandom_range(0, 1)), acc);
          default: offer(rand_inst(), {$urandom, $urandom}, 2);
        endcase
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);
      #5;
      chk("queue_empty", XL, 64'(q.size()), 64'd0);
      done_cnt++;
    end

    // Monitor: pops the expected bundle whenever the DUT's output is consumed or flushed.
    initial begin
      exp_t e;
      logic hold_p;
      logic [XL-1:0] pc_p, imm_p;
      logic [23:0] ctl_p;
      hold_p = 1'b0; pc_p = '0; imm_p = '0; ctl_p = '0;
      forever begin
        @(negedge clk);
        #2;
        if (rst) begin
          hold_p = 1'b0;
        end else begin
          if (hold_p) begin
            chk("hold_pc", XL, 64'(out_pc), 64'(pc_p));
            chk("hold_imm", XL, 64'(out_imm), 64'(imm_p));
            chk("hold_ctl", XL, 64'({out_aluop, out_wen, out_src1_pc, out_src2_imm, out_jump,
                                     out_illegal, out_rs1, out_rs2, out_rd}), 64'(ctl_p));
          end
          if (out_valid && (out_ready || flush)) begin
            if (q.size() == 0) begin
              total++; bad++;
              $display("FAIL sb_empty xlen=%0d got=out_valid want=no bundle", XL);
            end else begin
              e = q.pop_front();
              if (!flush) begin
                chk("pc", XL, 64'(out_pc), e.pc);
                chk("illegal", XL, 64'(out_illegal), 64'(e.illegal));
                chk("aluop", XL, 64'(out_aluop), 64'(e.aluop));
                chk("wen", XL, 64'(out_wen), 64'(e.wen));
                chk("jump", XL, 64'(out_jump), 64'(e.jump));
                chk("regs", XL, 64'({out_rs1, out_rs2, out_rd}), 64'({e.rs1, e.rs2, e.rd}));
                if (!e.illegal) begin
                  chk("src1_pc", XL, 64'(out_src1_pc), 64'(e.src1_pc));
                  chk("src2_imm", XL, 64'(out_src2_imm), 64'(e.src2_imm));
                  chk("imm", XL, 64'(out_imm), e.imm);
                end
              end
            end
          end
          hold_p = out_valid && !out_ready && !flush;
          pc_p = out_pc;
          imm_p = out_imm;
          ctl_p = {out_aluop, out_wen, out_src1_pc, out_src2_imm, out_jump,
                   out_illegal, out_rs1, out_rs2, out_rd};
        end
      end
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      #1_000_000;
    join_any
    disable fork;
    if (done_cnt != 2) begin
      total++; bad++;
      $display("FAIL run_timeout got done=%0d want=2", done_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
